// File: rtl/multiword_sequencer_if.sv
// Bus bundle for multiword_sequencer: command, operand and result streams
// plus the connection to the 16-bit arithmetic unit.
// The slave modport is the sequencer's view; master is the environment side.
interface multiword_sequencer_if #(
    parameter int LEN_W = 2
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_sel;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_carry_in;

    logic             op_valid;
    logic             op_ready;
    logic [15:0]      op_a;
    logic [15:0]      op_b;

    logic [15:0]      au_in_a;
    logic [15:0]      au_in_b;
    logic [3:0]       au_sel;
    logic             au_carry_in;
    logic [15:0]      au_result;
    logic             au_carry_out;
    logic             au_compare;

    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_data;
    logic             res_last;
    logic             res_carry;
    logic             res_equal;
    logic             res_zero;

    logic             busy;

    modport slave (
        input  cmd_valid, cmd_sel, cmd_len, cmd_carry_in,
        input  op_valid, op_a, op_b,
        input  au_result, au_carry_out, au_compare,
        input  res_ready,
        output cmd_ready, op_ready,
        output au_in_a, au_in_b, au_sel, au_carry_in,
        output res_valid, res_data, res_last, res_carry, res_equal, res_zero,
        output busy
    );

    modport master (
        output cmd_valid, cmd_sel, cmd_len, cmd_carry_in,
        output op_valid, op_a, op_b,
        output au_result, au_carry_out, au_compare,
        output res_ready,
        input  cmd_ready, op_ready,
        input  au_in_a, au_in_b, au_sel, au_carry_in,
        input  res_valid, res_data, res_last, res_carry, res_equal, res_zero,
        input  busy
    );
endinterface

// File: rtl/multiword_sequencer.sv
// multiword_sequencer: runs 1..2^LEN_W word operations on a 16-bit
// combinational arithmetic unit, least-significant word first, chaining
// carry_out into carry_in and streaming each result word out.
// LEN_W must match the LEN_W of the connected multiword_sequencer_if.
// Optional: define MSEQ_ZERO_FLAG_EN to enable the all-words-zero flag
// on res_zero; otherwise res_zero is tied low.
module multiword_sequencer #(
    parameter int LEN_W = 2
) (
    input logic                  clk,
    input logic                  rst,
    multiword_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        OUT
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic             eq_q;
`ifdef MSEQ_ZERO_FLAG_EN
    logic             zero_q;
`else
    assign bus.res_zero = 1'b0;
`endif

    // Control FSM; every output is registered. au_carry_in doubles as the
    // carry register so the next word sees the previous carry directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            len_q           <= '0;
            cnt_q           <= '0;
            eq_q            <= 1'b0;
            bus.cmd_ready   <= 1'b1;
            bus.op_ready    <= 1'b0;
            bus.res_valid   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.au_in_a     <= '0;
            bus.au_in_b     <= '0;
            bus.au_sel      <= '0;
            bus.au_carry_in <= 1'b0;
            bus.res_data    <= '0;
            bus.res_last    <= 1'b0;
            bus.res_carry   <= 1'b0;
            bus.res_equal   <= 1'b0;
`ifdef MSEQ_ZERO_FLAG_EN
            zero_q          <= 1'b0;
            bus.res_zero    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.au_sel      <= bus.cmd_sel;
                        bus.au_carry_in <= bus.cmd_carry_in;
                        len_q           <= bus.cmd_len;
                        cnt_q           <= '0;
                        eq_q            <= 1'b1;
`ifdef MSEQ_ZERO_FLAG_EN
                        zero_q          <= 1'b1;
`endif
                        bus.cmd_ready   <= 1'b0;
                        bus.busy        <= 1'b1;
                        bus.op_ready    <= 1'b1;
                        state           <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.op_valid && bus.op_ready) begin
                        bus.au_in_a  <= bus.op_a;
                        bus.au_in_b  <= bus.op_b;
                        bus.op_ready <= 1'b0;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    bus.res_data    <= bus.au_result;
                    bus.res_carry   <= bus.au_carry_out;
                    bus.au_carry_in <= bus.au_carry_out;
                    eq_q            <= eq_q & bus.au_compare;
                    bus.res_equal   <= eq_q & bus.au_compare;
                    bus.res_last    <= (cnt_q == len_q);
`ifdef MSEQ_ZERO_FLAG_EN
                    zero_q          <= zero_q & (bus.au_result == '0);
                    bus.res_zero    <= zero_q & (bus.au_result == '0);
`endif
                    bus.res_valid   <= 1'b1;
                    state           <= OUT;
                end
                OUT: begin
                    if (bus.res_valid && bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        if (bus.res_last) begin
                            bus.cmd_ready <= 1'b1;
                            bus.busy      <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            cnt_q        <= cnt_q + 1'b1;
                            bus.op_ready <= 1'b1;
                            state        <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_sequencer.sv
// Testbench for multiword_sequencer: bench-side model of the 16-bit unit
// (sel 1001 = add with carry, sel 0000 = xor, compare = a==b), table of
// commands with expected per-word results, scoreboard queue of results.
module tb_multiword_sequencer;
    localparam int LEN_W = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multiword_sequencer_if #(.LEN_W(LEN_W)) bus ();

    multiword_sequencer #(.LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference arithmetic unit
    logic [16:0] au_sum;
    always_comb begin
        au_sum           = {1'b0, bus.au_in_a} + {1'b0, bus.au_in_b} + {16'b0, bus.au_carry_in};
        bus.au_result    = bus.au_in_a;
        bus.au_carry_out = 1'b0;
        bus.au_compare   = (bus.au_in_a == bus.au_in_b);
        case (bus.au_sel)
            4'b1001: begin
                bus.au_result    = au_sum[15:0];
                bus.au_carry_out = au_sum[16];
            end
            4'b0000: bus.au_result = bus.au_in_a ^ bus.au_in_b;
            default: ;
        endcase
    end

    typedef struct packed {
        logic [15:0] data;
        logic        carry;
        logic        last;
        logic        equal;
        logic        zero;
        logic        cin;
    } exp_t;

    typedef struct packed {
        logic [3:0]       sel;
        logic [1:0]       len;
        logic             cin;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [3:0][15:0] d;
        logic [3:0]       c;
        logic [3:0]       e;
        logic [3:0]       z;
    } vec_t;

    vec_t tbl[7];
    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    function automatic vec_t mkv(input logic [3:0] sel, input logic [1:0] len, input logic cin,
                                 input logic [63:0] a, input logic [63:0] b, input logic [63:0] d,
                                 input logic [3:0] c, input logic [3:0] e, input logic [3:0] z);
        vec_t v;
        v.sel = sel; v.len = len; v.cin = cin;
        v.a = a; v.b = b; v.d = d;
        v.c = c; v.e = e; v.z = z;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic zexp(input logic z);
`ifdef MSEQ_ZERO_FLAG_EN
        return z;
`else
        return 1'b0 & z;
`endif
    endfunction

    task automatic send_cmd(input logic [3:0] sel, input logic [1:0] len, input logic cin);
        int n = 0;
        bus.cmd_sel      = sel;
        bus.cmd_len      = len;
        bus.cmd_carry_in = cin;
        bus.cmd_valid    = 1'b1;
        while (!bus.cmd_ready && n < 20) begin tick; n++; end
        chk("cmd_ready", bus.cmd_ready, 1);
        tick;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_op(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_valid = 1'b1;
        while (!bus.op_ready && n < 20) begin tick; n++; end
        chk("op_ready", bus.op_ready, 1);
        tick;
        bus.op_valid = 1'b0;
    endtask

    task automatic get_res(input bit bp);
        int   n = 0;
        exp_t e;
        while (!bus.res_valid && n < 20) begin tick; n++; end
        chk("res_valid", bus.res_valid, 1);
        chk("scoreboard_nonempty", (sbq.size() != 0), 1);
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        if (bp) begin
            bus.res_ready = 1'b0;
            repeat (5) begin
                tick;
                chk("bp_valid", bus.res_valid, 1);
                chk("bp_data", bus.res_data, e.data);
                chk("bp_last", bus.res_last, e.last);
                chk("bp_carry", bus.res_carry, e.carry);
                chk("bp_op_ready", bus.op_ready, 0);
                chk("bp_cmd_ready", bus.cmd_ready, 0);
            end
        end
        bus.res_ready = 1'b1;
        chk("res_data", bus.res_data, e.data);
        chk("res_carry", bus.res_carry, e.carry);
        chk("res_last", bus.res_last, e.last);
        chk("res_equal", bus.res_equal, e.equal);
        chk("res_zero", bus.res_zero, e.zero);
        tick;
        bus.res_ready = 1'b0;
        if (e.last) begin
            chk("idle_cmd_ready", bus.cmd_ready, 1);
            chk("idle_busy", bus.busy, 0);
        end else begin
            chk("next_op_ready", bus.op_ready, 1);
        end
    endtask

    task automatic run_cmd(input int k, input bit bp);
        vec_t v;
        exp_t e;
        logic pc;
        v = tbl[k];
        send_cmd(v.sel, v.len, v.cin);
        pc = v.cin;
        for (int w = 0; w <= int'(v.len); w++) begin
            send_op(v.a[w], v.b[w]);
            e.data  = v.d[w];
            e.carry = v.c[w];
            e.last  = (w == int'(v.len));
            e.equal = v.e[w];
            e.zero  = zexp(v.z[w]);
            e.cin   = pc;
            sbq.push_back(e);
            pc = v.c[w];
            chk("exec_carry_in", bus.au_carry_in, e.cin);
            chk("exec_sel", bus.au_sel, v.sel);
            tick;
            chk("latency", bus.res_valid, 1);
            get_res(bp && w == 0);
        end
    endtask

    // Cycle-level invariants between the handshakes
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("op_ready_res_valid_excl", bus.op_ready & bus.res_valid, 0);
            chk("cmd_ready_vs_busy", bus.cmd_ready, !bus.busy);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        exp_t e;
        tbl[0] = mkv(4'b1001, 2'd0, 1'b0,
                     {16'h0, 16'h0, 16'h0, 16'h0001}, {16'h0, 16'h0, 16'h0, 16'h0002},
                     {16'h0, 16'h0, 16'h0, 16'h0003}, 4'b0000, 4'b0000, 4'b0000);
        tbl[1] = mkv(4'b1001, 2'd1, 1'b0,
                     {16'h0, 16'h0, 16'h0000, 16'hFFFF}, {16'h0, 16'h0, 16'h0000, 16'h0001},
                     {16'h0, 16'h0, 16'h0001, 16'h0000}, 4'b0001, 4'b0000, 4'b0001);
        tbl[2] = mkv(4'b0000, 2'd1, 1'b0,
                     {16'h0, 16'h0, 16'hABCD, 16'h1234}, {16'h0, 16'h0, 16'hABCD, 16'h1234},
                     {16'h0, 16'h0, 16'h0000, 16'h0000}, 4'b0000, 4'b0011, 4'b0011);
        tbl[3] = mkv(4'b0000, 2'd1, 1'b0,
                     {16'h0, 16'h0, 16'hABCD, 16'h1234}, {16'h0, 16'h0, 16'hABCC, 16'h1234},
                     {16'h0, 16'h0, 16'h0001, 16'h0000}, 4'b0000, 4'b0001, 4'b0001);
        tbl[4] = mkv(4'b1001, 2'd1, 1'b0,
                     {16'h0, 16'h0, 16'hFFFF, 16'hFFFF}, {16'h0, 16'h0, 16'h0000, 16'h0001},
                     {16'h0, 16'h0, 16'h0000, 16'h0000}, 4'b0011, 4'b0000, 4'b0011);
        tbl[5] = mkv(4'b1001, 2'd3, 1'b1,
                     {16'h0001, 16'h8000, 16'hFFFF, 16'h0000}, {16'h0001, 16'h8000, 16'h0000, 16'h0000},
                     {16'h0003, 16'h0000, 16'hFFFF, 16'h0001}, 4'b0100, 4'b0001, 4'b0000);
        tbl[6] = mkv(4'b1001, 2'd0, 1'b0,
                     {16'h0, 16'h0, 16'h0, 16'h0005}, {16'h0, 16'h0, 16'h0, 16'h0006},
                     {16'h0, 16'h0, 16'h0, 16'h000B}, 4'b0000, 4'b0000, 4'b0000);

        bus.cmd_valid = 1'b0; bus.cmd_sel = '0; bus.cmd_len = '0; bus.cmd_carry_in = 1'b0;
        bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.res_ready = 1'b0;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_op_ready", bus.op_ready, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_res_last", bus.res_last, 0);
        chk("rst_res_zero", bus.res_zero, 0);
        chk("rst_au_in_a", bus.au_in_a, 0);
        chk("rst_au_sel", bus.au_sel, 0);
        chk("rst_au_carry_in", bus.au_carry_in, 0);
        mon_en = 1'b1;

        for (int k = 0; k < 6; k++) run_cmd(k, k == 1);

        // Reset in EXEC of word 1 of a 4-word add
        send_cmd(4'b1001, 2'd3, 1'b0);
        send_op(16'hFFFF, 16'h0001);
        e.data = 16'h0000; e.carry = 1'b1; e.last = 1'b0; e.equal = 1'b0;
        e.zero = zexp(1'b1); e.cin = 1'b0;
        sbq.push_back(e);
        tick;
        chk("latency_pre_rst", bus.res_valid, 1);
        get_res(1'b0);
        send_op(16'h0001, 16'h0001);
        chk("exec_before_rst_carry", bus.au_carry_in, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_res_valid", bus.res_valid, 0);
        chk("midrst_cmd_ready", bus.cmd_ready, 1);
        chk("midrst_op_ready", bus.op_ready, 0);
        chk("midrst_au_carry_in", bus.au_carry_in, 0);
        repeat (3) tick;
        chk("no_stale_res", bus.res_valid, 0);
        run_cmd(6, 1'b0);

        chk("scoreboard_drained", sbq.size(), 0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multiword_sequencer.md
Name: multiword_sequencer

Overview:
- Multi-precision controller wrapped around the 16-bit combinational arithmetic unit.
- Sits directly upstream and downstream of that unit. Feeds it one operand word pair per step and captures its arithmetic_out, carry_out and compare.
- Chains carry_out into carry_in for the next, more significant word, so 1..2^LEN_W word operations run least-significant word first.
- Result words leave through a valid/ready stream with last, carry and all-equal flags.

Parameters:
- LEN_W, 2, width of cmd_len; maximum operation length is 2^LEN_W words.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_sel  in  4  operation code passed unchanged to the unit's sel for every word
- cmd_len  in  LEN_W  number of words minus 1
- cmd_carry_in  in  1  carry_in for word 0
- op_valid  in  1  operand word pair offered
- op_ready  out  1  operand pair accepted when op_valid & op_ready
- op_a  in  16  operand A word
- op_b  in  16  operand B word
- au_in_a  out  16  to unit in_a
- au_in_b  out  16  to unit in_b
- au_sel  out  4  to unit sel
- au_carry_in  out  1  to unit carry_in
- au_result  in  16  from unit arithmetic_out
- au_carry_out  in  1  from unit carry_out
- au_compare  in  1  from unit compare
- res_valid  out  1  result word valid
- res_ready  in  1  result consumer ready
- res_data  out  16  result word
- res_last  out  1  high on the final word of the operation
- res_carry  out  1  captured au_carry_out for this word
- res_equal  out  1  AND of au_compare over words 0..current
- res_zero  out  1  see Optional Feature
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at a clock edge), effective next cycle:
  - state=IDLE; all outputs 0 except cmd_ready=1.
  - au_* driven 0; internal word counter, carry and equal registers cleared.
- Reset has priority over every handshake. Reset mid-operation discards partial results; no further res_valid is issued for that command.
- States:
  - IDLE: cmd_ready=1. On command handshake, latch sel, len and carry_in; word counter=0; equal register=1 → FETCH.
  - FETCH: op_ready=1. On operand handshake, register op_a/op_b into the au_in_a/au_in_b registers → EXEC.
  - EXEC: one cycle, no handshake. au_* are stable registered values, so the unit settles combinationally within the cycle. At the clock edge:
    - capture res_data=au_result and res_carry=au_carry_out;
    - equal register and res_equal take (equal & au_compare);
    - res_last=(counter==len);
    - carry register takes au_carry_out;
    - → OUT.
  - OUT: res_valid=1, all res_* held stable until res_ready.
    - On handshake with res_last=0: counter+1 → FETCH.
    - On handshake with res_last=1 → IDLE.
- au_carry_in is cmd_carry_in for word 0 and the registered carry for later words. au_sel holds the latched sel for the whole command.
- Carry is chained for every sel code, including codes whose result ignores carry_in; the unit defines the arithmetic.
- Latency: operand handshake in cycle t → EXEC in t+1 → res_valid in t+2.
- Minimum of 3 cycles per word with res_ready and op_valid held high.
- cmd_ready=0 whenever busy=1; commands are never queued.
- op_ready and res_valid are never high in the same cycle.
- cmd_len=0 gives a single-word operation with res_last=1.
- cmd_len=2^LEN_W-1: the counter reaches len without wrapping.
- No simultaneous-event conflicts exist, because each state has exactly one handshake.

Optional Feature:
- Macro MSEQ_ZERO_FLAG_EN.
- Defined: a zero register is set to 1 at command accept. In EXEC it is ANDed with (au_result==0). res_zero presents it with each word, so on res_last it reads 1 only if every result word was 0x0000.
- Undefined: no zero register; res_zero is tied to 0.

Test Plan:
All scenarios use the 16-bit arithmetic unit connected to the au_* ports.
- Single add: sel=4'b1001, len=0, carry_in=0, a=0x0001, b=0x0002 → one word; res_data=0x0003, res_last=1, res_carry=0, res_equal=0; res_valid 2 cycles after the operand handshake.
- Carry chain: sel=4'b1001, len=1, carry_in=0, words (0xFFFF,0x0001) then (0x0000,0x0000) → word0 res_data=0x0000, res_carry=1; word1 au_carry_in=1, res_data=0x0001, res_carry=0, res_last=1.
- Equality:
  - sel=4'b0000, len=1, pairs (0x1234,0x1234),(0xABCD,0xABCD) → res_equal=1 on both words.
  - Repeat with second b=0xABCC → word1 res_equal=0.
- Backpressure: res_ready low 5 cycles in OUT → res_valid=1 and res_data/res_last/res_carry unchanged; op_ready=0 and cmd_ready=0 throughout; word advances the cycle after res_ready=1.
- Reset mid-op: len=3, assert rst during EXEC of word 1 → next cycle busy=0, res_valid=0, cmd_ready=1. A following single-word add 0x0005+0x0006 returns 0x000B with carry_in from the new command.
- Zero flag with MSEQ_ZERO_FLAG_EN:
  - sel=4'b1001, len=1, pairs (0xFFFF,0x0001),(0xFFFF,0x0000) with carry_in=0 → words 0x0000, 0x0000 (carry), res_zero=1 on last.
  - Without the macro, res_zero=0 always.
